// File: rtl/perceptron_predictor.sv
// Perceptron branch predictor inference: PC-indexed dot product against the speculative GHR,
// in-order queue of in-flight predictions for training/repair. Optional counters: PERCEPTRON_STATS_EN.
module perceptron_predictor #(
  parameter int PERCEPTRON_NUMBER = 64,
  parameter int HISTORY_SIZE      = 16,
  parameter int WEIGHT_NUMBER     = HISTORY_SIZE + 1,
  parameter int WIDTH             = 8,
  parameter int QUEUE_DEPTH       = 4,
  localparam int IW = $clog2(PERCEPTRON_NUMBER),
  localparam int SW = WIDTH + $clog2(WEIGHT_NUMBER) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [31:0]              i_req_pc,
  input  logic [PERCEPTRON_NUMBER-1:0][WEIGHT_NUMBER-1:0][WIDTH-1:0] i_weights,
  output logic                     o_pred_valid,
  output logic                     o_prediction,
  input  logic                     i_res_valid,
  input  logic                     i_res_outcome,
  output logic                     o_train_valid,
  output logic [IW-1:0]            o_train_perceptron,
  output logic [HISTORY_SIZE-1:0]  o_train_history,
  output logic                     o_train_prediction,
  output logic signed [SW-1:0]     o_train_sum,
  output logic                     o_flush,
  output logic [31:0]              o_stat_pred,
  output logic [31:0]              o_stat_mispred
);
  localparam int QW = $clog2(QUEUE_DEPTH);

  typedef struct packed {
    logic [IW-1:0]           idx;
    logic [HISTORY_SIZE-1:0] hist;
    logic                    pred;
    logic signed [SW-1:0]    sum;
  } entry_t;

  logic [HISTORY_SIZE-1:0] ghr;
  entry_t                  q [QUEUE_DEPTH];
  logic [QW-1:0]           rd_ptr, wr_ptr;
  logic [QW:0]             count;

  logic [IW-1:0]                        idx;
  logic [WEIGHT_NUMBER-1:0][WIDTH-1:0]  sel_w;
  logic signed [SW-1:0]                 sum;
  entry_t                               head, new_e;
  logic                                 full, pop, mispred, accept;
  logic                                 unused_pc;

  assign idx       = i_req_pc[IW+1:2];
  assign unused_pc = ^{i_req_pc[31:IW+2], i_req_pc[1:0]};
  assign sel_w     = i_weights[idx];

  // Bias plus +/- each history weight; SW leaves headroom so no overflow.
  always_comb begin
    sum = SW'($signed(sel_w[0]));
    for (int i = 1; i < WEIGHT_NUMBER; i++) begin
      if (ghr[i-1]) sum = sum + SW'($signed(sel_w[i]));
      else          sum = sum - SW'($signed(sel_w[i]));
    end
  end

  assign head        = q[rd_ptr];
  assign full        = (count == (QW+1)'(QUEUE_DEPTH));
  assign pop         = i_res_valid && (count != '0);
  assign mispred     = pop && (i_res_outcome != head.pred);
  assign o_req_ready = !full && !mispred;
  assign accept      = i_req_valid && o_req_ready;

  always_comb begin
    new_e      = '0;
    new_e.idx  = idx;
    new_e.hist = ghr;
    new_e.pred = (sum >= 0);
    new_e.sum  = sum;
  end

  always_ff @(posedge clk) begin
    if (accept) q[wr_ptr] <= new_e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mispred) begin
      // Repair history from the mispredicted branch's snapshot, drop everything in flight.
      ghr    <= {head.hist[HISTORY_SIZE-2:0], i_res_outcome};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        ghr    <= {ghr[HISTORY_SIZE-2:0], new_e.pred};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + (QW+1)'(1);
        2'b01:   count <= count - (QW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pred_valid       <= 1'b0;
      o_prediction       <= 1'b0;
      o_train_valid      <= 1'b0;
      o_train_perceptron <= '0;
      o_train_history    <= '0;
      o_train_prediction <= 1'b0;
      o_train_sum        <= '0;
      o_flush            <= 1'b0;
    end else begin
      o_pred_valid  <= accept;
      o_prediction  <= accept & new_e.pred;
      o_train_valid <= pop;
      o_flush       <= mispred;
      if (pop) begin
        o_train_perceptron <= head.idx;
        o_train_history    <= head.hist;
        o_train_prediction <= head.pred;
        o_train_sum        <= head.sum;
      end
    end
  end

`ifdef PERCEPTRON_STATS_EN
  logic [31:0] stat_pred, stat_mispred;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pred    <= '0;
      stat_mispred <= '0;
    end else begin
      if (accept  && stat_pred    != '1) stat_pred    <= stat_pred + 32'd1;
      if (mispred && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
    end
  end
  assign o_stat_pred    = stat_pred;
  assign o_stat_mispred = stat_mispred;
`else
  assign o_stat_pred    = '0;
  assign o_stat_mispred = '0;
`endif
endmodule

// File: tb/tb_perceptron_predictor.sv
// Directed + randomized bench for perceptron_predictor against a queue-based reference model.
module tb_perceptron_predictor;
  localparam int P = 64, H = 16, WN = 17, W = 8, D = 4, IW = 6, SW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 i_req_valid, i_res_valid, i_res_outcome;
  logic [31:0]          i_req_pc;
  logic [P-1:0][WN-1:0][W-1:0] i_weights;
  logic                 o_req_ready, o_pred_valid, o_prediction, o_train_valid;
  logic [IW-1:0]        o_train_perceptron;
  logic [H-1:0]         o_train_history;
  logic                 o_train_prediction, o_flush;
  logic signed [SW-1:0] o_train_sum;
  logic [31:0]          o_stat_pred, o_stat_mispred;

  perceptron_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_pc(i_req_pc),
    .i_weights(i_weights),
    .o_pred_valid(o_pred_valid), .o_prediction(o_prediction),
    .i_res_valid(i_res_valid), .i_res_outcome(i_res_outcome),
    .o_train_valid(o_train_valid), .o_train_perceptron(o_train_perceptron),
    .o_train_history(o_train_history), .o_train_prediction(o_train_prediction),
    .o_train_sum(o_train_sum), .o_flush(o_flush),
    .o_stat_pred(o_stat_pred), .o_stat_mispred(o_stat_mispred)
  );

  typedef struct {
    int         idx;
    logic [15:0] hist;
    logic       pred;
    int         sum;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mghr;
  int          w [P][WN];
  int          checks = 0, errors = 0;
  int          m_pred = 0, m_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_weights();
    for (int p = 0; p < P; p++)
      for (int i = 0; i < WN; i++)
        i_weights[p][i] = w[p][i][7:0];
  endtask

  task automatic rand_weights();
    for (int p = 0; p < P; p++)
      for (int i = 0; i < WN; i++)
        w[p][i] = int'($urandom_range(0, 255)) - 128;
    apply_weights();
  endtask

  // One cycle: drive at negedge, check ready, advance model, check registered outputs next negedge.
  task automatic step(input logic req, input logic [31:0] pc, input logic res, input logic outc);
    logic exp_rdy, acc, pop, mis;
    ent_t e, h;
    int   s, id;
    i_req_valid = req; i_req_pc = pc; i_res_valid = res; i_res_outcome = outc;
    #1;
    pop = res && (mq.size() > 0);
    mis = 1'b0;
    if (pop) begin
      h   = mq[0];
      mis = (outc != h.pred);
    end
    exp_rdy = (mq.size() != D) && !mis;
    chk("req_ready", o_req_ready, exp_rdy);
    acc = req && exp_rdy;
    id  = int'(pc[7:2]);
    s   = w[id][0];
    for (int i = 1; i < WN; i++) s += mghr[i-1] ? w[id][i] : -w[id][i];
    e.idx = id; e.hist = mghr; e.pred = (s >= 0); e.sum = s;
    if (mis) begin
      mghr = {h.hist[14:0], outc};
      mq.delete();
      m_mis++;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(e);
        mghr = {mghr[14:0], e.pred};
        m_pred++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0; i_res_valid = 1'b0;
    chk("pred_valid", o_pred_valid, acc);
    if (acc) chk("prediction", o_prediction, e.pred);
    chk("train_valid", o_train_valid, pop);
    if (pop) begin
      chk("train_perceptron", o_train_perceptron, h.idx);
      chk("train_history", o_train_history, h.hist);
      chk("train_prediction", o_train_prediction, h.pred);
      chk("train_sum", o_train_sum, h.sum);
    end
    chk("flush", o_flush, mis);
`ifdef PERCEPTRON_STATS_EN
    chk("stat_pred", o_stat_pred, m_pred);
    chk("stat_mispred", o_stat_mispred, m_mis);
`else
    chk("stat_pred_tied", o_stat_pred, 0);
    chk("stat_mispred_tied", o_stat_mispred, 0);
`endif
  endtask

  initial begin
    i_req_valid = 1'b0; i_res_valid = 1'b0; i_res_outcome = 1'b0; i_req_pc = '0;
    for (int p = 0; p < P; p++)
      for (int i = 0; i < WN; i++) w[p][i] = 0;
    apply_weights();
    mghr = '0;
    #12;
    chk("rst_ready", o_req_ready, 1'b1);
    chk("rst_pred_valid", o_pred_valid, 1'b0);
    chk("rst_train_valid", o_train_valid, 1'b0);
    chk("rst_flush", o_flush, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero weights: sum 0 predicts taken; next snapshot shows history 1.
    step(1'b1, 32'h0, 1'b0, 1'b0);
    chk("zero_w_pred", o_prediction, 1'b1);
    step(1'b1, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("ghr_after_first", o_train_history, 16'h0001);

    // Perceptron 3 negative bias -> not taken, resolves taken -> mispredict.
    w[3][0] = -1;
    apply_weights();
    step(1'b1, 32'h0C, 1'b0, 1'b0);
    chk("p3_pred", o_prediction, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("p3_idx", o_train_perceptron, 3);
    chk("p3_sum", o_train_sum, -1);
    chk("p3_flush", o_flush, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, mq[0].pred);
    chk("p3_repair", o_train_history, 16'h0007);

    // Fill queue, then correct resolve while full keeps ready low; accepted next cycle.
    rand_weights();
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, mq[0].pred);
    step(1'b1, $urandom, 1'b0, 1'b0);
    while (mq.size() > 0) step(1'b0, 32'h0, 1'b1, mq[0].pred);

    // Three queued, oldest mispredicts: flush, one record, later resolves ignored.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, !mq[0].pred);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Mid-flight reset with two queued and outputs active.
    step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, mq[0].pred);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pred_valid", o_pred_valid, 1'b0);
    chk("mid_rst_prediction", o_prediction, 1'b0);
    chk("mid_rst_train_valid", o_train_valid, 1'b0);
    chk("mid_rst_train_sum", o_train_sum, 0);
    chk("mid_rst_flush", o_flush, 1'b0);
    chk("mid_rst_ready", o_req_ready, 1'b1);
    mq.delete(); mghr = '0; m_pred = 0; m_mis = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, mq[0].pred);

    // Randomized traffic with occasional weight changes.
    for (int n = 0; n < 600; n++) begin
      if (n % 16 == 0) rand_weights();
      step(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 3) == 0) ? 1'($urandom) : (mq.size() > 0 ? mq[0].pred : 1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
